// File: rtl/dma_pkg.sv
// Shared FSM encodings, register map and CTRL bit positions for the dma_copy engine.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_RD     = 3'd2,
    ST_RD_GAP = 3'd3,
    ST_WR     = 3'd4,
    ST_WR_GAP = 3'd5
  } dma_state_e;

  localparam logic [7:0] REG_SRC_HI = 8'h00;
  localparam logic [7:0] REG_SRC_LO = 8'h02;
  localparam logic [7:0] REG_DST_HI = 8'h04;
  localparam logic [7:0] REG_DST_LO = 8'h06;
  localparam logic [7:0] REG_LEN    = 8'h08;
  localparam logic [7:0] REG_CTRL   = 8'h0A;

  // CTRL write bits
  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_ABORT    = 1;
  localparam int unsigned CTRL_CLR_DONE = 2;
  localparam int unsigned CTRL_IE       = 3;
  // CTRL read bits
  localparam int unsigned CTRL_BUSY     = 0;
  localparam int unsigned CTRL_DONE     = 1;
  localparam int unsigned CTRL_ABORTED  = 2;

  // Byte-lane merge of a slave write into the current register word.
  function automatic logic [15:0] merge_bytes(input logic [15:0] cur, input logic [15:0] wr,
                                              input logic hi, input logic lo);
    return {hi ? wr[15:8] : cur[15:8], lo ? wr[7:0] : cur[7:0]};
  endfunction

endpackage

// File: rtl/dma_regs.sv
// dma_regs: slave decode, one-shot ack and CTRL handling for dma_copy.
// The interrupt-enable bit exists only when DMA_IRQ_EN is defined.
module dma_regs
  import dma_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [15:0]      i_data_write,
  output logic [15:0]      o_data_read,
  input  logic [7:0]       i_addr,
  input  logic             i_uds,
  input  logic             i_lds,
  input  logic             i_rw,
  output logic             o_ack,
  input  logic             i_busy,
  input  logic             i_done,
  input  logic             i_aborted,
  input  logic [31:0]      i_src,
  input  logic [31:0]      i_dst,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_src_hi_we_c,
  output logic             o_src_lo_we_c,
  output logic             o_dst_hi_we_c,
  output logic             o_dst_lo_we_c,
  output logic             o_len_we_c,
  output logic [15:0]      o_wdata_c,
  output logic             o_start_c,
  output logic             o_abort_c,
  output logic             o_clr_done_c,
  output logic             o_ie
);

  logic        r_ack;
  logic [15:0] r_data_read;
  logic        w_sel;
  logic        w_fire;
  logic        w_ctrl_wr;
  logic [15:0] w_rdata;

  assign w_sel  = i_uds | i_lds;
  // A write commits only on the cycle ack rises, so a long strobe writes once.
  assign w_fire = w_sel & ~r_ack & ~i_rw;

  always_comb begin
    w_rdata = '0;
    case (i_addr)
      REG_SRC_HI: w_rdata = i_src[31:16];
      REG_SRC_LO: w_rdata = i_src[15:0];
      REG_DST_HI: w_rdata = i_dst[31:16];
      REG_DST_LO: w_rdata = i_dst[15:0];
      REG_LEN:    w_rdata = 16'(i_len);
      REG_CTRL: begin
        w_rdata[CTRL_BUSY]    = i_busy;
        w_rdata[CTRL_DONE]    = i_done;
        w_rdata[CTRL_ABORTED] = i_aborted;
        w_rdata[CTRL_IE]      = o_ie;
      end
      default: w_rdata = '0;
    endcase
  end

  assign o_wdata_c     = merge_bytes(w_rdata, i_data_write, i_uds, i_lds);
  assign o_src_hi_we_c = w_fire & ~i_busy & (i_addr == REG_SRC_HI);
  assign o_src_lo_we_c = w_fire & ~i_busy & (i_addr == REG_SRC_LO);
  assign o_dst_hi_we_c = w_fire & ~i_busy & (i_addr == REG_DST_HI);
  assign o_dst_lo_we_c = w_fire & ~i_busy & (i_addr == REG_DST_LO);
  assign o_len_we_c    = w_fire & ~i_busy & (i_addr == REG_LEN);

  // Abort wins over a simultaneous start.
  assign w_ctrl_wr    = w_fire & i_lds & (i_addr == REG_CTRL);
  assign o_abort_c    = w_ctrl_wr & i_data_write[CTRL_ABORT];
  assign o_start_c    = w_ctrl_wr & i_data_write[CTRL_START] & ~i_data_write[CTRL_ABORT] & ~i_busy;
  assign o_clr_done_c = w_ctrl_wr & i_data_write[CTRL_CLR_DONE];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ack       <= 1'b0;
      r_data_read <= '0;
    end else begin
      r_ack <= w_sel;
      if (w_sel && i_rw) r_data_read <= w_rdata;
    end
  end

`ifdef DMA_IRQ_EN
  logic r_ie;
  always_ff @(posedge i_clk) begin
    if (i_reset)        r_ie <= 1'b0;
    else if (w_ctrl_wr) r_ie <= i_data_write[CTRL_IE];
  end
  assign o_ie = r_ie;
`else
  assign o_ie = 1'b0;
`endif

  assign o_ack       = r_ack;
  assign o_data_read = r_data_read;

endmodule

// File: rtl/dma_copy.sv
// dma_copy: bus-master word copy engine (SRC -> DST, LEN words) with a register slave port.
// Define DMA_IRQ_EN to enable the done interrupt; otherwise irq stays 0.
module dma_copy
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       data_write,
  output logic [15:0]       data_read,
  input  logic [7:0]        addr,
  input  logic              uds,
  input  logic              lds,
  input  logic              rw,
  output logic              ack,
  output logic [ADDR_W-1:0] m_addr,
  output logic [15:0]       m_write,
  input  logic [15:0]       m_read,
  output logic              m_as,
  output logic              m_uds,
  output logic              m_lds,
  output logic              m_rw,
  input  logic              m_ack,
  output logic              m_br,
  input  logic              m_bg,
  output logic              irq
);

  dma_state_e        r_state;
  logic [ADDR_W-1:0] r_src, r_dst, r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [15:0]       r_write;
  logic              r_as, r_rw, r_br, r_done, r_aborted, r_abort_pend, r_irq;
  logic              w_busy, w_start, w_abort, w_clr_done, w_ie, w_abort_any, w_step, w_done_nxt;
  logic              w_src_hi_we, w_src_lo_we, w_dst_hi_we, w_dst_lo_we, w_len_we;
  logic [15:0]       w_wdata;
  logic [31:0]       w_src32, w_dst32;

  assign w_busy      = (r_state != ST_IDLE);
  assign w_src32     = 32'(r_src);
  assign w_dst32     = 32'(r_dst);
  assign w_abort_any = r_abort_pend | w_abort;
  assign w_step      = (r_state == ST_WR) && m_ack;

  dma_regs #(.LEN_W(LEN_W)) u_regs (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_data_write  (data_write),
    .o_data_read   (data_read),
    .i_addr        (addr),
    .i_uds         (uds),
    .i_lds         (lds),
    .i_rw          (rw),
    .o_ack         (ack),
    .i_busy        (w_busy),
    .i_done        (r_done),
    .i_aborted     (r_aborted),
    .i_src         (w_src32),
    .i_dst         (w_dst32),
    .i_len         (r_len),
    .o_src_hi_we_c (w_src_hi_we),
    .o_src_lo_we_c (w_src_lo_we),
    .o_dst_hi_we_c (w_dst_hi_we),
    .o_dst_lo_we_c (w_dst_lo_we),
    .o_len_we_c    (w_len_we),
    .o_wdata_c     (w_wdata),
    .o_start_c     (w_start),
    .o_abort_c     (w_abort),
    .o_clr_done_c  (w_clr_done),
    .o_ie          (w_ie)
  );

  // Address/length counters: software loads while idle, advance once per completed write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
    end else if (w_step) begin
      r_src <= r_src + ADDR_W'(2);
      r_dst <= r_dst + ADDR_W'(2);
      r_len <= r_len - LEN_W'(1);
    end else begin
      if (w_src_hi_we) r_src <= ADDR_W'({w_wdata, w_src32[15:0]});
      if (w_src_lo_we) r_src <= ADDR_W'({w_src32[31:16], w_wdata});
      if (w_dst_hi_we) r_dst <= ADDR_W'({w_wdata, w_dst32[15:0]});
      if (w_dst_lo_we) r_dst <= ADDR_W'({w_dst32[31:16], w_wdata});
      if (w_len_we)    r_len <= LEN_W'(w_wdata);
    end
  end

  // Completion sets done; an accepted start or clear-done drops it.
  always_comb begin
    w_done_nxt = r_done;
    if (w_start)                                     w_done_nxt = (r_len == '0);
    else if ((r_state == ST_WR_GAP) && (r_len == '0)) w_done_nxt = 1'b1;
    else if (w_clr_done)                             w_done_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_write      <= '0;
      r_as         <= 1'b0;
      r_rw         <= 1'b1;
      r_br         <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_irq  <= w_done_nxt & w_ie;
      if (w_abort && w_busy) r_abort_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_aborted <= 1'b0;
            if (r_len != '0) begin
              r_br    <= 1'b1;
              r_state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (w_abort_any) begin
            r_br         <= 1'b0;
            r_aborted    <= 1'b1;
            r_abort_pend <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (m_bg) begin
            r_as    <= 1'b1;
            r_rw    <= 1'b1;
            r_addr  <= {r_src[ADDR_W-1:1], 1'b0};
            r_state <= ST_RD;
          end
        end
        ST_RD: begin
          if (m_ack) begin
            r_as    <= 1'b0;
            r_write <= m_read;
            r_state <= ST_RD_GAP;
          end
        end
        // Write half waits here for the grant if it was lost during the read.
        ST_RD_GAP: begin
          if (w_abort_any) begin
            r_br         <= 1'b0;
            r_aborted    <= 1'b1;
            r_abort_pend <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (m_bg) begin
            r_as    <= 1'b1;
            r_rw    <= 1'b0;
            r_addr  <= {r_dst[ADDR_W-1:1], 1'b0};
            r_state <= ST_WR;
          end
        end
        ST_WR: begin
          if (m_ack) begin
            r_as    <= 1'b0;
            r_rw    <= 1'b1;
            r_state <= ST_WR_GAP;
          end
        end
        ST_WR_GAP: begin
          if (r_len == '0) begin
            r_br         <= 1'b0;
            r_abort_pend <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (w_abort_any) begin
            r_br         <= 1'b0;
            r_aborted    <= 1'b1;
            r_abort_pend <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (!m_bg) begin
            r_state <= ST_REQ;
          end else begin
            r_as    <= 1'b1;
            r_rw    <= 1'b1;
            r_addr  <= {r_src[ADDR_W-1:1], 1'b0};
            r_state <= ST_RD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_addr  = r_addr;
  assign m_write = r_write;
  assign m_as    = r_as;
  assign m_uds   = r_as;
  assign m_lds   = r_as;
  assign m_rw    = r_rw;
  assign m_br    = r_br;
  assign irq     = r_irq;

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: register slave accesses plus a bus target with programmable wait states.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_write = '0;
  logic [15:0] data_read;
  logic [7:0]  addr = '0;
  logic        uds = 1'b0, lds = 1'b0, rw = 1'b1;
  logic        ack;
  logic [23:0] m_addr;
  logic [15:0] m_write;
  logic [15:0] m_read = '0;
  logic        m_as, m_uds, m_lds, m_rw;
  logic        m_ack = 1'b0;
  logic        m_br;
  logic        m_bg = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int stall = 0;
  int t_wait = 0;
  int strobe_err = 0;
  int mon_as = 0, mon_br = 0;
  logic mon_en = 1'b0;
  logic [23:0] rd_a[$];
  logic [23:0] wr_a[$];
  logic [15:0] wr_d[$];

  dma_copy #(.ADDR_W(24), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .data_write(data_write), .data_read(data_read),
    .addr(addr), .uds(uds), .lds(lds), .rw(rw), .ack(ack),
    .m_addr(m_addr), .m_write(m_write), .m_read(m_read),
    .m_as(m_as), .m_uds(m_uds), .m_lds(m_lds), .m_rw(m_rw),
    .m_ack(m_ack), .m_br(m_br), .m_bg(m_bg), .irq(irq)
  );

  always #5 clk = ~clk;

  // Bus target: acks after 'stall' wait cycles; read data = low address half XOR 5A5A.
  always @(posedge clk) begin
    if (m_as && (!m_uds || !m_lds)) strobe_err <= strobe_err + 1;
    if (m_as && !m_ack) begin
      if (t_wait >= stall) begin
        m_ack  <= 1'b1;
        t_wait <= 0;
        if (m_rw) begin
          m_read <= 16'(m_addr) ^ 16'h5A5A;
          rd_a.push_back(m_addr);
        end else begin
          wr_a.push_back(m_addr);
          wr_d.push_back(m_write);
        end
      end else begin
        t_wait <= t_wait + 1;
      end
    end else begin
      m_ack  <= 1'b0;
      t_wait <= 0;
    end
  end

  always @(negedge clk) begin
    if (mon_en && m_as) mon_as++;
    if (mon_en && m_br) mon_br++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; data_write = d; rw = 1'b0; uds = 1'b1; lds = 1'b1;
    @(negedge clk);
    check("wr_ack", 32'(ack), 32'd1);
    uds = 1'b0; lds = 1'b0; rw = 1'b1;
    @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] d;
    @(negedge clk);
    addr = a; rw = 1'b1; uds = 1'b1; lds = 1'b1;
    @(negedge clk);
    check("rd_ack", 32'(ack), 32'd1);
    d = data_read;
    uds = 1'b0; lds = 1'b0;
    @(negedge clk);
    check(tag, 32'(d), 32'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (m_br !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_br_low"}, 32'(m_br), 32'd0);
  endtask

  task automatic clear_logs();
    rd_a.delete(); wr_a.delete(); wr_d.delete();
  endtask

  initial begin
    int n;
    int viol;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_read", 32'(data_read), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_m_addr", 32'(m_addr), 32'd0);
    check("rst_m_write", 32'(m_write), 32'd0);
    check("rst_strobes", 32'({m_as, m_uds, m_lds}), 32'd0);
    check("rst_m_rw", 32'(m_rw), 32'd1);
    check("rst_m_br", 32'(m_br), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;

    // Basic three-word copy
    m_bg = 1'b1; stall = 0;
    reg_wr(8'h00, 16'h0000); reg_wr(8'h02, 16'h1000);
    reg_wr(8'h04, 16'h0000); reg_wr(8'h06, 16'h2000);
    reg_wr(8'h08, 16'd3);
    rd_chk("len_rb", 8'h08, 16'd3);
    reg_wr(8'h0A, 16'h0001);
    wait_idle("copy");
    check("copy_nrd", 32'(rd_a.size()), 32'd3);
    check("copy_nwr", 32'(wr_a.size()), 32'd3);
    check("copy_rd0", 32'(rd_a[0]), 32'h001000);
    check("copy_rd1", 32'(rd_a[1]), 32'h001002);
    check("copy_rd2", 32'(rd_a[2]), 32'h001004);
    check("copy_wa0", 32'(wr_a[0]), 32'h002000);
    check("copy_wa1", 32'(wr_a[1]), 32'h002002);
    check("copy_wa2", 32'(wr_a[2]), 32'h002004);
    check("copy_wd0", 32'(wr_d[0]), 32'h4A5A);
    check("copy_wd1", 32'(wr_d[1]), 32'h4A58);
    check("copy_wd2", 32'(wr_d[2]), 32'h4A5E);
    rd_chk("copy_ctrl", 8'h0A, 16'h0002);
    rd_chk("copy_src_lo", 8'h02, 16'h1006);
    rd_chk("copy_dst_lo", 8'h06, 16'h2006);
    rd_chk("copy_len", 8'h08, 16'h0000);

    // Zero-length start: done without any bus activity
    reg_wr(8'h0A, 16'h0004);
    rd_chk("clr_done_ctrl", 8'h0A, 16'h0000);
    clear_logs(); mon_as = 0; mon_br = 0; mon_en = 1'b1;
    reg_wr(8'h0A, 16'h0001);
    rd_chk("len0_ctrl", 8'h0A, 16'h0002);
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    check("len0_as", 32'(mon_as), 32'd0);
    check("len0_br", 32'(mon_br), 32'd0);

    // Grant hold-off, plus LEN write ignored while busy
    m_bg = 1'b0; clear_logs();
    reg_wr(8'h02, 16'h3000); reg_wr(8'h06, 16'h4000); reg_wr(8'h08, 16'd1);
    reg_wr(8'h0A, 16'h0001);
    check("hold_br", 32'(m_br), 32'd1);
    reg_wr(8'h08, 16'd7);
    rd_chk("hold_len_busy", 8'h08, 16'd1);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_br !== 1'b1 || m_as !== 1'b0) viol++;
    end
    check("hold_viol", 32'(viol), 32'd0);
    m_bg = 1'b1;
    @(negedge clk);
    check("hold_first_as", 32'(m_as), 32'd1);
    check("hold_first_addr", 32'(m_addr), 32'h003000);
    check("hold_first_rw", 32'(m_rw), 32'd1);
    wait_idle("hold");
    check("hold_wa", 32'(wr_a[0]), 32'h004000);
    check("hold_wd", 32'(wr_d[0]), 32'h6A5A);
    rd_chk("hold_len_end", 8'h08, 16'd0);

    // Grant drop during a write
    stall = 3; clear_logs();
    reg_wr(8'h02, 16'h5000); reg_wr(8'h06, 16'h6000); reg_wr(8'h08, 16'd2);
    reg_wr(8'h0A, 16'h0001);
    n = 0;
    while (!(m_as === 1'b1 && m_rw === 1'b0) && n < 200) begin @(negedge clk); n++; end
    check("gd_wr_seen", 32'(m_as & ~m_rw), 32'd1);
    m_bg = 1'b0;
    n = 0;
    while (wr_a.size() < 1 && n < 200) begin @(negedge clk); n++; end
    check("gd_nwr1", 32'(wr_a.size()), 32'd1);
    @(negedge clk);
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_as !== 1'b0) viol++;
    end
    check("gd_as_quiet", 32'(viol), 32'd0);
    check("gd_br_held", 32'(m_br), 32'd1);
    check("gd_nrd1", 32'(rd_a.size()), 32'd1);
    m_bg = 1'b1;
    wait_idle("gd");
    check("gd_rd1", 32'(rd_a[1]), 32'h005002);
    check("gd_wa0", 32'(wr_a[0]), 32'h006000);
    check("gd_wa1", 32'(wr_a[1]), 32'h006002);
    check("gd_wd0", 32'(wr_d[0]), 32'h0A5A);
    check("gd_wd1", 32'(wr_d[1]), 32'h0A58);

    // Abort during a stalled read
    stall = 5; clear_logs();
    reg_wr(8'h02, 16'h7000); reg_wr(8'h06, 16'h8000); reg_wr(8'h08, 16'd4);
    reg_wr(8'h0A, 16'h0001);
    n = 0;
    while (!(m_as === 1'b1 && m_rw === 1'b1) && n < 200) begin @(negedge clk); n++; end
    check("ab_rd_seen", 32'(m_as & m_rw), 32'd1);
    reg_wr(8'h0A, 16'h0002);
    wait_idle("ab");
    check("ab_nrd", 32'(rd_a.size()), 32'd1);
    check("ab_rd0", 32'(rd_a[0]), 32'h007000);
    check("ab_nwr", 32'(wr_a.size()), 32'd0);
    rd_chk("ab_ctrl", 8'h0A, 16'h0004);
    rd_chk("ab_src", 8'h02, 16'h7000);
    rd_chk("ab_len", 8'h08, 16'd4);
    stall = 0;

    // Start and abort together: nothing starts
    mon_as = 0; mon_en = 1'b1;
    reg_wr(8'h0A, 16'h0003);
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    check("sa_br", 32'(m_br), 32'd0);
    check("sa_as", 32'(mon_as), 32'd0);

    // Unmapped offset
    reg_wr(8'h0C, 16'hBEEF);
    rd_chk("unmapped", 8'h0C, 16'h0000);

    // Address wrap and optional interrupt
    clear_logs();
    reg_wr(8'h00, 16'hFFFF);
    rd_chk("src_hi_mask", 8'h00, 16'h00FF);
    reg_wr(8'h02, 16'hFFFE); reg_wr(8'h06, 16'h9000); reg_wr(8'h08, 16'd2);
    reg_wr(8'h0A, 16'h0009);
    wait_idle("wrap");
    check("wrap_nrd", 32'(rd_a.size()), 32'd2);
    check("wrap_rd0", 32'(rd_a[0]), 32'hFFFFFE);
    check("wrap_rd1", 32'(rd_a[1]), 32'h000000);
    check("wrap_wd0", 32'(wr_d[0]), 32'hA5A4);
    check("wrap_wd1", 32'(wr_d[1]), 32'h5A5A);
    check("wrap_wa1", 32'(wr_a[1]), 32'h009002);
    rd_chk("wrap_src_hi", 8'h00, 16'h0000);
    rd_chk("wrap_src_lo", 8'h02, 16'h0002);
`ifdef DMA_IRQ_EN
    check("irq_done", 32'(irq), 32'd1);
`else
    check("irq_done", 32'(irq), 32'd0);
`endif
    reg_wr(8'h0A, 16'h000C);
    check("irq_clr", 32'(irq), 32'd0);
`ifdef DMA_IRQ_EN
    rd_chk("ctrl_ie", 8'h0A, 16'h0008);
`else
    rd_chk("ctrl_ie", 8'h0A, 16'h0000);
`endif

    // Reset mid-transfer drops the strobes on the next edge
    stall = 5;
    reg_wr(8'h02, 16'h1000); reg_wr(8'h08, 16'd2);
    reg_wr(8'h0A, 16'h0001);
    n = 0;
    while (m_as !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("rstx_as_seen", 32'(m_as), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rstx_as", 32'(m_as), 32'd0);
    check("rstx_br", 32'(m_br), 32'd0);
    reset = 1'b0;
    stall = 0;
    rd_chk("rstx_ctrl", 8'h0A, 16'h0000);

    check("strobe_match", 32'(strobe_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
